// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Pops one word from an FWFT FIFO when idle and shifts it out as an
// asynchronous serial frame: start bit, 5..8 data bits LSB first, optional
// parity bit, then 1 or 2 stop bits. Bit timing comes from an internal
// down-counter reloaded with the latched divisor at the start of every bit.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_tx_en              allows a new frame to start (never aborts one)
//   i_baud_div           bit period minus one, in clocks
//   i_data_bits          0..3 -> 5..8 data bits
//   i_parity_en/_odd     parity insertion and sense
//   i_stop2              two stop bits when set
//   i_fifo_data/_valid   FWFT head word and its valid flag
//   i_fifo_parity_error  head word failed its storage parity check
//   o_fifo_rd_req        combinational pop strobe
//   o_txd                registered serial line, idles high
//   o_busy               a frame is on the line
//   o_done / o_drop      single-cycle frame-complete / word-discarded pulses
module uart_tx_serializer #(
    parameter int DW    = 8,
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tx_en,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic [1:0]       i_data_bits,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_stop2,
    input  logic [DW-1:0]    i_fifo_data,
    input  logic             i_fifo_valid,
    input  logic             i_fifo_parity_error,
    output logic             o_fifo_rd_req,
    output logic             o_txd,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_drop
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       shift_r, shift_s;
    logic [DIV_W-1:0] cnt_r, cnt_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [2:0]       idx_r, idx_s;
    logic [2:0]       last_r, last_s;
    logic             par_en_r, par_en_s;
    logic             stop2_r, stop2_s;
    logic             par_bit_r, par_bit_s;
    logic             txd_s, done_s, drop_s, pop_s, bit_end_s;
    logic             unused_data_s;

    // Parity over the low 5..8 bits of the word, inverted for odd parity.
    function automatic logic frame_parity(input logic [7:0] data,
                                          input logic [1:0] bits,
                                          input logic       odd);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - bits);
        return (^(data & mask)) ^ odd;
    endfunction

    // Bits above [7:0] of a wider FIFO word are never serialized.
    assign unused_data_s = ^i_fifo_data;

    assign pop_s         = (state_r == ST_IDLE) & i_tx_en & i_fifo_valid & ~i_rst;
    assign o_fifo_rd_req = pop_s;
    assign bit_end_s     = (cnt_r == {DIV_W{1'b0}});

    // Next-state and next-datapath logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        cnt_s     = cnt_r;
        div_s     = div_r;
        idx_s     = idx_r;
        last_s    = last_r;
        par_en_s  = par_en_r;
        stop2_s   = stop2_r;
        par_bit_s = par_bit_r;
        done_s    = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    // Configuration is captured here so later input changes
                    // cannot disturb the frame being sent.
                    shift_s   = i_fifo_data[7:0];
                    div_s     = i_baud_div;
                    cnt_s     = i_baud_div;
                    idx_s     = 3'd0;
                    last_s    = 3'd4 + {1'b0, i_data_bits};
                    par_en_s  = i_parity_en;
                    stop2_s   = i_stop2;
                    par_bit_s = frame_parity(i_fifo_data[7:0], i_data_bits, i_parity_odd);
                    if (i_fifo_parity_error) begin
                        drop_s = 1'b1;
                    end else begin
                        state_s = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cnt_s   = div_r;
                    idx_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s   = div_r;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (idx_r == last_r) begin
                        idx_s   = 3'd0;
                        state_s = par_en_r ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    cnt_s   = div_r;
                    idx_s   = 3'd0;
                end else begin
                    cnt_s = cnt_r - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (stop2_r && (idx_r == 3'd0)) begin
                        idx_s = 3'd1;
                        cnt_s = div_r;
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so o_txd can be a plain register.
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            ST_START:  txd_s = 1'b0;
            ST_DATA:   txd_s = shift_s[0];
            ST_PARITY: txd_s = par_bit_s;
            ST_STOP:   txd_s = 1'b1;
            ST_IDLE:   txd_s = 1'b1;
            default:   txd_s = 1'b1;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'd0;
            cnt_r     <= {DIV_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            idx_r     <= 3'd0;
            last_r    <= 3'd0;
            par_en_r  <= 1'b0;
            stop2_r   <= 1'b0;
            par_bit_r <= 1'b0;
            o_txd     <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_drop    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            idx_r     <= idx_s;
            last_r    <= last_s;
            par_en_r  <= par_en_s;
            stop2_r   <= stop2_s;
            par_bit_r <= par_bit_s;
            o_txd     <= txd_s;
            o_busy    <= (state_s != ST_IDLE);
            o_done    <= done_s;
            o_drop    <= drop_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_tx_en;
    logic [15:0] i_baud_div;
    logic [1:0]  i_data_bits;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_stop2;
    logic [7:0]  i_fifo_data;
    logic        i_fifo_valid;
    logic        i_fifo_parity_error;
    logic        o_fifo_rd_req;
    logic        o_txd;
    logic        o_busy;
    logic        o_done;
    logic        o_drop;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  bits;
        logic        pe;
        logic        po;
        logic        s2;
        logic [15:0] div;
        bit          b2b;
        int          exp_len;
        int          exp_par;
    } vec_t;

    vec_t tbl[7];

    uart_tx_serializer #(.DW(8), .DIV_W(16)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_tx_en             (i_tx_en),
        .i_baud_div          (i_baud_div),
        .i_data_bits         (i_data_bits),
        .i_parity_en         (i_parity_en),
        .i_parity_odd        (i_parity_odd),
        .i_stop2             (i_stop2),
        .i_fifo_data         (i_fifo_data),
        .i_fifo_valid        (i_fifo_valid),
        .i_fifo_parity_error (i_fifo_parity_error),
        .o_fifo_rd_req       (o_fifo_rd_req),
        .o_txd               (o_txd),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_drop              (o_drop)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected line levels, one entry per bit period, from the frame rules.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] bits,
                                        input logic pe, input logic po, input logic s2);
        int n, ones;
        n = 5 + int'(bits);
        ones = 0;
        exp_q.delete();
        exp_q.push_back(0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        if (pe) exp_q.push_back((ones % 2) ^ int'(po));
        exp_q.push_back(1);
        if (s2) exp_q.push_back(1);
    endfunction

    // Idle cycles: line high, no strobes.
    task automatic idle_chk(input int n, input logic exp_rd, input string nm);
        repeat (n) begin
            @(posedge i_clk); #1;
            chk({nm, "_idle"}, {27'd0, o_txd, o_busy, o_done, o_drop, o_fifo_rd_req},
                {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, exp_rd});
        end
    endtask

    // Called #1 after a clock edge with the DUT idle. Pops one word, scrambles
    // the inputs, then follows the frame until o_busy drops (bounded).
    task automatic send(input logic [7:0] d, input logic [1:0] bits, input logic pe,
                        input logic po, input logic s2, input logic [15:0] div,
                        input int exp_len, input int exp_par, input bit hold, input string nm);
        int w, len, cnt, mism, pidx, ev;
        int obs[$];
        build_frame(d, bits, pe, po, s2);
        w   = int'(div) + 1;
        len = exp_q.size() * w;
        i_fifo_data = d; i_data_bits = bits; i_parity_en = pe; i_parity_odd = po;
        i_stop2 = s2; i_baud_div = div; i_tx_en = 1'b1; i_fifo_valid = 1'b1;
        i_fifo_parity_error = 1'b0;
        #1;
        chk({nm, "_rdreq"}, {31'd0, o_fifo_rd_req}, 32'd1);
        @(posedge i_clk); #1;
        if (hold) begin
            i_tx_en = 1'b0;
            i_fifo_valid = 1'b1;
        end else begin
            i_fifo_valid = 1'b0;
        end
        i_fifo_data = ~d; i_data_bits = ~bits; i_parity_en = ~pe; i_parity_odd = ~po;
        i_stop2 = ~s2; i_baud_div = div + 16'd5;
        cnt = 0; mism = 0;
        while (o_busy === 1'b1 && cnt < 400) begin
            ev = (cnt / w < exp_q.size()) ? exp_q[cnt / w] : 2;
            if (ev == 2 || o_txd !== ev[0] || o_fifo_rd_req !== 1'b0 || o_done !== 1'b0)
                mism++;
            obs.push_back(int'(o_txd));
            cnt++;
            @(posedge i_clk); #1;
        end
        chk({nm, "_len"}, cnt, (exp_len >= 0) ? exp_len : len);
        chk({nm, "_wave"}, mism, 32'd0);
        chk({nm, "_done"}, {29'd0, o_done, o_busy, o_txd}, {29'd0, 3'b101});
        if (exp_par >= 0) begin
            pidx = (6 + int'(bits)) * w;
            chk({nm, "_par"}, (pidx < obs.size()) ? obs[pidx] : -1, exp_par);
        end
    endtask

    initial begin
        tbl[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 40, -1}; // 8N1
        tbl[1] = '{8'h41, 2'd2, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 10,  0}; // 7E1
        tbl[2] = '{8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 10,  1}; // 7O1
        tbl[3] = '{8'h1F, 2'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 16, -1}; // 5N2
        tbl[4] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 16, -1}; // 5N2 b2b
        tbl[5] = '{8'hFF, 2'd3, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 36,  1}; // 8O2
        tbl[6] = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 18,  1}; // 6E1 b2b

        i_rst = 1'b1; i_tx_en = 1'b1; i_fifo_valid = 1'b1; i_fifo_data = 8'h5A;
        i_fifo_parity_error = 1'b0; i_baud_div = 16'd0; i_data_bits = 2'd3;
        i_parity_en = 1'b0; i_parity_odd = 1'b0; i_stop2 = 1'b0;
        #12;
        chk("rst_state", {27'd0, o_txd, o_busy, o_done, o_drop, o_fifo_rd_req}, {27'd0, 5'b10000});
        @(negedge i_clk);
        i_fifo_valid = 1'b0;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        idle_chk(2, 1'b0, "post_rst");

        for (int i = 0; i < 7; i++) begin
            if (!tbl[i].b2b) idle_chk(2, 1'b0, $sformatf("tbl%0d", i));
            send(tbl[i].data, tbl[i].bits, tbl[i].pe, tbl[i].po, tbl[i].s2, tbl[i].div,
                 tbl[i].exp_len, tbl[i].exp_par, 1'b0, $sformatf("tbl%0d", i));
        end

        // Storage parity error: word consumed, nothing sent, drop pulse.
        idle_chk(1, 1'b0, "perr_pre");
        i_fifo_data = 8'h3C; i_fifo_valid = 1'b1; i_fifo_parity_error = 1'b1; i_tx_en = 1'b1;
        #1;
        chk("perr_rdreq", {31'd0, o_fifo_rd_req}, 32'd1);
        @(posedge i_clk); #1;
        i_fifo_valid = 1'b0; i_fifo_parity_error = 1'b0;
        chk("perr_drop", {28'd0, o_drop, o_txd, o_busy, o_done}, {28'd0, 4'b1100});
        @(posedge i_clk); #1;
        chk("perr_drop_end", {28'd0, o_drop, o_txd, o_busy, o_done}, {28'd0, 4'b0100});
        idle_chk(1, 1'b0, "perr_post");
        send(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 16'd0, 10, -1, 1'b0, "perr_next");

        // tx_en dropped and config changed mid-frame; no pop while disabled.
        idle_chk(1, 1'b0, "txen_pre");
        send(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 16'd1, 20, -1, 1'b1, "txen");
        idle_chk(4, 1'b0, "txen_off");
        send(8'h69, 2'd3, 1'b1, 1'b0, 1'b0, 16'd0, 11, 0, 1'b0, "txen_on");

        // Reset during DATA aborts the frame immediately.
        idle_chk(1, 1'b0, "abort_pre");
        i_fifo_data = 8'h55; i_data_bits = 2'd3; i_parity_en = 1'b0; i_stop2 = 1'b0;
        i_baud_div = 16'd3; i_tx_en = 1'b1; i_fifo_valid = 1'b1;
        @(posedge i_clk); #1;
        i_fifo_valid = 1'b0;
        repeat (6) @(posedge i_clk);
        #2;
        chk("abort_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1; i_fifo_valid = 1'b1;
        #1;
        chk("abort_state", {27'd0, o_txd, o_busy, o_done, o_drop, o_fifo_rd_req}, {27'd0, 5'b10000});
        @(negedge i_clk);
        i_rst = 1'b0; i_fifo_valid = 1'b0;
        @(posedge i_clk); #1;
        idle_chk(1, 1'b0, "abort_post");
        send(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 16'd2, 30, -1, 1'b0, "abort_next");

        // Randomized frames against the bit-list model.
        for (int k = 0; k < 24; k++) begin
            logic [7:0]  rd;
            logic [1:0]  rb;
            logic [15:0] rdiv;
            rd   = 8'($urandom);
            rb   = 2'($urandom_range(0, 3));
            rdiv = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle_chk($urandom_range(1, 3), 1'b0, "rnd");
            send(rd, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rdiv, -1, -1, 1'b0, $sformatf("rnd%0d", k));
        end
        idle_chk(2, 1'b0, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer for the UART TX path. It sits directly downstream of the TX look-ahead (FWFT) FIFO. It pops one word when idle, then shifts out a complete asynchronous frame on `o_txd`: start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing comes from an internal programmable divider, so no external baud tick is needed.

## Interface
Parameters:
- `DW`, 8: FIFO word width; only bits [7:0] are serialized, and `DW` must be ≥ 8.
- `DIV_W`, 16: width of the baud divisor.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_tx_en`  in  1  permits new frames to start; a frame in progress always completes.
- `i_baud_div`  in  DIV_W  bit period minus one, in clocks.
- `i_data_bits`  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
- `i_parity_en`  in  1  inserts a parity bit.
- `i_parity_odd`  in  1  1=odd parity, 0=even parity.
- `i_stop2`  in  1  1=two stop bits, 0=one.
- `i_fifo_data`  in  DW  FWFT head word.
- `i_fifo_valid`  in  1  head word is valid.
- `i_fifo_parity_error`  in  1  the FIFO storage parity check failed on the head word.
- `o_fifo_rd_req`  out  1  pop strobe, combinational.
- `o_txd`  out  1  serial output; idle level is 1.
- `o_busy`  out  1  a frame is on the line.
- `o_done`  out  1  one-clock pulse when a frame completes.
- `o_drop`  out  1  one-clock pulse when a word is discarded because of a storage parity error.

## Operation
- The FSM states are IDLE, START, DATA, PARITY and STOP.
- **Pop condition.** In IDLE, `o_fifo_rd_req` = `i_tx_en & i_fifo_valid`. It is never asserted in any other state. In the pop cycle the block latches:
  - `i_fifo_data[7:0]` into the shift register;
  - all configuration inputs (`i_data_bits`, `i_parity_en`, `i_parity_odd`, `i_stop2`, `i_baud_div`).
- Configuration changes take effect only on the next pop; they never affect the frame in progress.
- **Storage parity error.** If `i_fifo_parity_error`=1 in the pop cycle, the word is still consumed but no frame is sent. The FSM stays in IDLE, `o_txd` stays 1, and `o_drop` pulses in the following cycle.
- **Normal pop.** The FSM moves IDLE→START.
- **Bit timer.** The bit counter loads `i_baud_div` on entry to each bit and counts down to 0. Every bit lasts `i_baud_div`+1 clocks. `i_baud_div`=0 gives one clock per bit.
- **Bit sequence:**
  - START drives 0.
  - DATA drives `shift[0]` and shifts right each bit; it stays for N bits (N = 5 + `i_data_bits`).
  - PARITY is entered only if parity is enabled. It drives the XOR of the N data bits, inverted for odd parity.
  - STOP drives 1 for 1 or 2 bit periods.
- **Frame length** is (1 + N + P + S)·(`i_baud_div`+1) clocks, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- At the end of STOP the FSM returns to IDLE, and `o_done` pulses in that IDLE-entry cycle.
- **Back-to-back frames.** The pop can occur in that same IDLE-entry cycle, so consecutive frames are separated by exactly one clock of idle high.
- `o_busy` = 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- Deasserting `i_tx_en` mid-frame has no effect on the current frame; it only blocks the next pop.
- **Reset.** Asserting `i_rst`, including mid-frame, forces the following immediately (asynchronously):
  - FSM to IDLE;
  - `o_txd`=1;
  - `o_busy`=0, `o_done`=0, `o_drop`=0;
  - bit and shift counters to 0.
- `o_fifo_rd_req` is held at 0 while `i_rst`=1. The aborted word is lost; no partial-frame recovery is required.

## Timing
- **Reset values:** `o_txd`=1, `o_busy`=0, `o_done`=0, `o_drop`=0, `o_fifo_rd_req`=0.
- **Pop to start bit:** the pop is at cycle t. `o_txd` falls at t+1 and `o_busy` rises at t+1.
- `o_txd` is registered and glitch-free. Each bit value is held for exactly `i_baud_div`+1 clocks.
- `o_done` rises in the clock after the last stop-bit clock and lasts one clock. `o_busy` falls in that same clock.
- `o_drop` is asserted at t+1 for a pop at t, and no other output changes.
- `o_fifo_rd_req` is combinational from `i_fifo_valid`, `i_tx_en` and the FSM state. The upstream FWFT FIFO must present its next word combinationally by the following cycle.

## Test plan
- **8N1.** Set div=3 and push 0xA5. `o_txd` must show 0,1,0,1,0,0,1,0,1,1, with each bit lasting 4 clocks. Total frame is 40 clocks. `o_done` pulses once at clock 41 after the pop.
- **7E1 and 7O1.** Set div=0 and push 0x41. The data bits are 1,0,0,0,0,0,1. Even parity must be 0 and odd parity must be 1. The frame is 10 clocks.
- **5N2 back-to-back.** Set div=1 and push 0x1F then 0x00. Each frame is 16 clocks. Exactly one idle-high clock separates the frames, and two `o_done` pulses are seen.
- **Storage parity error.** The head word has `i_fifo_parity_error`=1. Expect a one-cycle `o_fifo_rd_req`, an `o_drop` pulse the next cycle, and `o_txd` held at 1. The next clean word then transmits normally.
- **`i_tx_en` and configuration stability.** Drop `i_tx_en` and change `i_data_bits` mid-frame. The current frame completes unchanged, and no further pop occurs while `i_tx_en`=0.
- **Mid-frame reset.** Assert `i_rst` during DATA. `o_txd`=1 and `o_busy`=0 immediately. After release, a fresh pop starts a clean frame.
